// File: rtl/uart_cpld_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_cpld_pkg
// Brief    : Shared FSM state encoding and bit-timing constants for the
//            CPLD-side UART responder.
// Revision : 1.0  initial release
// ============================================================================
package uart_cpld_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int unsigned c_TICKS_PER_BIT = 16;
    localparam int unsigned c_MID_TICK      = 8;

    // Terminal values of the 4-bit per-bit tick counters.
    localparam logic [3:0] c_BIT_LAST = 4'(c_TICKS_PER_BIT - 1);
    localparam logic [3:0] c_MID_LAST = 4'(c_MID_TICK - 1);

endpackage
`default_nettype wire

// File: rtl/uart_cpld_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_cpld_rx
// Brief    : 8N1 receiver driven by the shared 16x tick; start-bit glitch
//            rejection at mid-bit, framing-error discard at the stop bit.
// Revision : 1.0  initial release
// ============================================================================
module uart_cpld_rx
    import uart_cpld_pkg::*;
(
    input  logic       clk_bus,
    input  logic       rst,
    input  logic       tick,
    input  logic       rxd_s,
    output logic [7:0] rx_byte,
    output logic       rx_valid
);

    uart_state_t r_state;
    uart_state_t w_state_nxt;
    logic [3:0]  r_tick_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_valid;
    logic        w_sample;

    // The start bit is checked half a bit in; every later sample is a full bit on.
    assign w_sample = tick &&
                      (r_tick_cnt == ((r_state == ST_START) ? c_MID_LAST : c_BIT_LAST));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (!rxd_s) w_state_nxt = ST_START;
            ST_START: if (w_sample) w_state_nxt = rxd_s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (w_sample && (r_bit_cnt == 3'd7)) w_state_nxt = ST_STOP;
            ST_STOP:  if (w_sample) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_bus) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tick_cnt <= 4'd0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_valid    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= 1'b0;
            if (r_state == ST_IDLE) begin
                r_tick_cnt <= 4'd0;
                r_bit_cnt  <= 3'd0;
            end else if (w_sample) begin
                r_tick_cnt <= 4'd0;
            end else if (tick) begin
                r_tick_cnt <= r_tick_cnt + 4'd1;
            end
            if ((r_state == ST_DATA) && w_sample) begin
                r_shift   <= {rxd_s, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if ((r_state == ST_STOP) && w_sample && rxd_s) begin
                r_valid <= 1'b1;
            end
        end
    end

    assign rx_byte  = r_shift;
    assign rx_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/uart_cpld_phy.sv
`default_nettype none
// ============================================================================
// Module   : uart_cpld_phy
// Brief    : CPLD responder for the bridge strobe bus: THR + 8N1 transmitter,
//            RBR fed by uart_cpld_rx, strobe synchronisers and status flags.
// Revision : 1.0  initial release
// ============================================================================
module uart_cpld_phy
    import uart_cpld_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk_bus,
    input  logic       rst,
    input  logic       wrn,
    input  logic       rdn,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       data_oe,
    output logic       tready,
    output logic       tsre,
    output logic       data_ready,
    input  logic       rxd,
    output logic       txd
);

    localparam int DIV = CLK_HZ / (BAUD * 16);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] c_DIV_LAST = TW'(DIV - 1);

    logic [2:0]    r_wrn_sync, r_rdn_sync;
    logic [1:0]    r_rxd_sync;
    logic [7:0]    r_data_d1, r_data_d2, r_stage;
    logic          w_wr_commit, w_rd_done;
    logic [TW-1:0] r_tick_cnt;
    logic          w_tick;

    uart_state_t r_tx_state, w_tx_nxt;
    logic        r_txd, w_txd_nxt;
    logic [7:0]  r_thr, r_tx_shift;
    logic        r_tready, r_tsre;
    logic [3:0]  r_tx_cnt;
    logic [2:0]  r_tx_bit;
    logic        w_tx_bit_end, w_tx_load, w_wr_accept;

    logic [7:0]  r_rbr, w_rx_byte;
    logic        r_data_ready, w_rx_valid;

    assign w_wr_commit = r_wrn_sync[1] & ~r_wrn_sync[2];
    assign w_rd_done   = r_rdn_sync[1] & ~r_rdn_sync[2];
    assign w_tick      = (r_tick_cnt == c_DIV_LAST);

    // data_i is delayed to match the wrn synchroniser, so the staged byte is
    // the one present while the raw strobe was still low.
    always_ff @(posedge clk_bus) begin
        if (rst) begin
            r_wrn_sync <= 3'b111;
            r_rdn_sync <= 3'b111;
            r_rxd_sync <= 2'b11;
            r_data_d1  <= 8'h00;
            r_data_d2  <= 8'h00;
            r_stage    <= 8'h00;
            r_tick_cnt <= '0;
        end else begin
            r_wrn_sync <= {r_wrn_sync[1:0], wrn};
            r_rdn_sync <= {r_rdn_sync[1:0], rdn};
            r_rxd_sync <= {r_rxd_sync[0], rxd};
            r_data_d1  <= data_i;
            r_data_d2  <= r_data_d1;
            if (!r_wrn_sync[1]) r_stage <= r_data_d2;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
        end
    end

    assign w_tx_bit_end = w_tick && (r_tx_cnt == c_BIT_LAST);
    // A load empties THR in the same cycle, so a coincident write is kept.
    assign w_wr_accept  = w_wr_commit && (r_tready || w_tx_load);

    always_comb begin
        w_tx_nxt  = r_tx_state;
        w_txd_nxt = r_txd;
        w_tx_load = 1'b0;
        case (r_tx_state)
            ST_IDLE: if (!r_tready) begin
                w_tx_nxt  = ST_START;
                w_txd_nxt = 1'b0;
                w_tx_load = 1'b1;
            end
            ST_START: if (w_tx_bit_end) begin
                w_tx_nxt  = ST_DATA;
                w_txd_nxt = r_tx_shift[0];
            end
            ST_DATA: if (w_tx_bit_end) begin
                if (r_tx_bit == 3'd7) begin
                    w_tx_nxt  = ST_STOP;
                    w_txd_nxt = 1'b1;
                end else begin
                    w_txd_nxt = r_tx_shift[1];
                end
            end
            ST_STOP: if (w_tx_bit_end) begin
                if (!r_tready) begin
                    w_tx_nxt  = ST_START;
                    w_txd_nxt = 1'b0;
                    w_tx_load = 1'b1;
                end else begin
                    w_tx_nxt  = ST_IDLE;
                    w_txd_nxt = 1'b1;
                end
            end
            default: w_tx_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_bus) begin
        if (rst) begin
            r_tx_state   <= ST_IDLE;
            r_txd        <= 1'b1;
            r_thr        <= 8'h00;
            r_tready     <= 1'b1;
            r_tsre       <= 1'b1;
            r_tx_shift   <= 8'h00;
            r_tx_cnt     <= 4'd0;
            r_tx_bit     <= 3'd0;
            r_rbr        <= 8'h00;
            r_data_ready <= 1'b0;
        end else begin
            r_tx_state <= w_tx_nxt;
            r_txd      <= w_txd_nxt;
            if (w_wr_accept) r_thr <= r_stage;
            if (w_wr_accept)    r_tready <= 1'b0;
            else if (w_tx_load) r_tready <= 1'b1;
            if (w_tx_load) r_tsre <= 1'b0;
            else if ((r_tx_state == ST_STOP) && w_tx_bit_end) r_tsre <= 1'b1;
            if (w_tx_load) r_tx_shift <= r_thr;
            else if ((r_tx_state == ST_DATA) && w_tx_bit_end) r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            if (w_tx_load || w_tx_bit_end) r_tx_cnt <= 4'd0;
            else if (w_tick && (r_tx_state != ST_IDLE)) r_tx_cnt <= r_tx_cnt + 4'd1;
            if ((r_tx_state == ST_START) && w_tx_bit_end) r_tx_bit <= 3'd0;
            else if ((r_tx_state == ST_DATA) && w_tx_bit_end) r_tx_bit <= r_tx_bit + 3'd1;
            // A completing frame beats a coincident read; overrun simply overwrites.
            if (w_rx_valid) begin
                r_rbr        <= w_rx_byte;
                r_data_ready <= 1'b1;
            end else if (w_rd_done) begin
                r_data_ready <= 1'b0;
            end
        end
    end

    uart_cpld_rx u_rx (
        .clk_bus  (clk_bus),
        .rst      (rst),
        .tick     (w_tick),
        .rxd_s    (r_rxd_sync[1]),
        .rx_byte  (w_rx_byte),
        .rx_valid (w_rx_valid)
    );

    assign data_o     = r_rbr;
    assign data_oe    = ~rdn;
    assign tready     = r_tready;
    assign tsre       = r_tsre;
    assign data_ready = r_data_ready;
    assign txd        = r_txd;

endmodule
`default_nettype wire
